rom_sample_streamer: RTL and testbench

//   Client-side reader for the shared ROM port arbiter. Walks a sample index 0..sampleCount-1 at a

---
 rtl/rom_sample_streamer.sv | 128 ++++++++++++
 tb/tb_rom_sample_streamer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_sample_streamer.sv
// Client-side ROM sample reader: walks indices at a fixed sample rate, waits out the
// arbiter read latency, and presents each captured word on a valid/ready handshake.
module rom_sample_streamer #(
    parameter int CLK_DIV       = 6250,
    parameter int FETCH_LATENCY = 8,
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16
) (
    input  logic              CLK_50Mhz,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] sampleCount,
    output logic [ADDR_W-1:0] accessIndex,
    input  logic [DATA_W-1:0] romDataIn,
    output logic [DATA_W-1:0] sampleOut,
    output logic              sampleValid,
    input  logic              sampleReady,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LAT_W  = (FETCH_LATENCY > 1) ? $clog2(FETCH_LATENCY) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(FETCH_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT,
        WAIT_TICK
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic [LAT_W-1:0]  latency;
    logic              tick;
    logic              last_index;
    logic              handshake;

    assign busy       = (state != IDLE);
    assign tick       = busy && (tick_cnt == TICK_LAST);
    assign last_index = (accessIndex == sampleCount - ADDR_W'(1));
    assign handshake  = sampleValid && sampleReady;

    // Sample-rate divider; held at zero while idle so every clip starts on a fresh period.
    always_ff @(posedge CLK_50Mhz) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values, independent of block ordering.
        if (reset || !busy || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TICK_W'(1);
    end

    always_ff @(posedge CLK_50Mhz) begin
        if (reset) begin
            state       <= IDLE;
            accessIndex <= '0;
            sampleOut   <= '0;
            sampleValid <= 1'b0;
            done        <= 1'b0;
            underrun    <= 1'b0;
            latency     <= '0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                // Abort wins over everything; the last sample and the underrun flag are kept.
                state       <= IDLE;
                sampleValid <= 1'b0;
                accessIndex <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && sampleCount != '0) begin
                            accessIndex <= '0;
                            latency     <= LAT_INIT;
                            underrun    <= 1'b0;
                            state       <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (tick)
                            underrun <= 1'b1;
                        if (latency == '0) begin
                            sampleOut   <= romDataIn;
                            sampleValid <= 1'b1;
                            state       <= PRESENT;
                        end else begin
                            latency <= latency - LAT_W'(1);
                        end
                    end
                    PRESENT: begin
                        if (tick)
                            underrun <= 1'b1;
                        if (handshake) begin
                            sampleValid <= 1'b0;
                            if (last_index) begin
                                accessIndex <= '0;
                                if (loop_en) begin
                                    state <= WAIT_TICK;
                                end else begin
                                    done  <= 1'b1;
                                    state <= IDLE;
                                end
                            end else begin
                                accessIndex <= accessIndex + ADDR_W'(1);
                                state       <= WAIT_TICK;
                            end
                        end
                    end
                    WAIT_TICK: begin
                        // Index moved on the handshake edge, so the arbiter already has it.
                        if (tick) begin
                            latency <= LAT_INIT;
                            state   <= FETCH;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_sample_streamer.sv
// Scoreboard bench for rom_sample_streamer with a delayed-ROM arbiter model.
module tb_rom_sample_streamer;

    localparam int CD    = 20;
    localparam int FL    = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int BOUND = 3 * CD;

    logic          CLK_50Mhz = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic [AW-1:0] sampleCount;
    logic [AW-1:0] accessIndex;
    logic [DW-1:0] romDataIn;
    logic [DW-1:0] sampleOut;
    logic          sampleValid;
    logic          sampleReady;
    logic          busy;
    logic          done;
    logic          underrun;

    int errors     = 0;
    int checks     = 0;
    int done_count = 0;
    logic [DW-1:0] exp_q[$];

    // Arbiter model: word for an index appears FL-1 edges after the index changes.
    logic [AW-1:0] idx_pipe[FL-1];

    always #5 CLK_50Mhz = ~CLK_50Mhz;

    always @(posedge CLK_50Mhz) begin
        idx_pipe[0] <= accessIndex;
        for (int i = 1; i < FL - 1; i++)
            idx_pipe[i] <= idx_pipe[i-1];
    end

    assign romDataIn = 16'h0100 + idx_pipe[FL-2];

    rom_sample_streamer #(
        .CLK_DIV      (CD),
        .FETCH_LATENCY(FL),
        .ADDR_W       (AW),
        .DATA_W       (DW)
    ) dut (
        .CLK_50Mhz  (CLK_50Mhz),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .sampleCount(sampleCount),
        .accessIndex(accessIndex),
        .romDataIn  (romDataIn),
        .sampleOut  (sampleOut),
        .sampleValid(sampleValid),
        .sampleReady(sampleReady),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    // Scoreboard: every handshake pops one expected sample.
    always begin
        @(negedge CLK_50Mhz);
        #1;
        if (done)
            done_count++;
        if (!reset && sampleValid && sampleReady) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample got=%h expected=none", sampleOut);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (sampleOut !== e) begin
                    errors++;
                    $display("FAIL sample_data got=%h expected=%h", sampleOut, e);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge CLK_50Mhz);
        start = 1'b1;
        @(negedge CLK_50Mhz);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!sampleValid && n < BOUND) begin
            @(negedge CLK_50Mhz);
            n++;
        end
        if (!sampleValid) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout got=0 expected=1 after %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge CLK_50Mhz);
        reset = 1'b0;
        @(negedge CLK_50Mhz);
        checks++;
        if ({busy, done, sampleValid, underrun} !== 4'b0000 || accessIndex !== '0 || sampleOut !== '0) begin
            errors++;
            $display("FAIL reset_state got=%b idx=%h out=%h expected=0000 idx=0 out=0",
                     {busy, done, sampleValid, underrun}, accessIndex, sampleOut);
        end
    endtask

    task automatic test_one_shot();
        int n;
        int d0;
        d0          = done_count;
        sampleCount = 4;
        loop_en     = 1'b0;
        sampleReady = 1'b1;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(16'h0100 + 16'(i));
        pulse_start();
        wait_valid(n);
        checks++;
        if (n != FL) begin
            errors++;
            $display("FAIL first_latency got=%0d expected=%0d", n, FL);
        end
        for (int i = 1; i < 4; i++) begin
            @(negedge CLK_50Mhz);
            wait_valid(n);
            checks++;
            if (n + 1 != CD) begin
                errors++;
                $display("FAIL sample_interval got=%0d expected=%0d", n + 1, CD);
            end
        end
        @(negedge CLK_50Mhz);
        checks++;
        if ({done, busy, sampleValid} !== 3'b100 || accessIndex !== '0) begin
            errors++;
            $display("FAIL one_shot_end got=%b idx=%h expected=100 idx=0",
                     {done, busy, sampleValid}, accessIndex);
        end
        @(negedge CLK_50Mhz);
        checks++;
        if (done !== 1'b0 || done_count - d0 != 1 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse got=%b/%0d/%b expected=0/1/0", done, done_count - d0, underrun);
        end
    endtask

    task automatic test_loop();
        int n;
        int d0;
        d0          = done_count;
        sampleCount = 3;
        loop_en     = 1'b1;
        sampleReady = 1'b1;
        for (int i = 0; i < 7; i++)
            exp_q.push_back(16'h0100 + 16'(i % 3));
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            wait_valid(n);
            if (i == 6)
                stop = 1'b1;
            @(negedge CLK_50Mhz);
            stop = 1'b0;
        end
        checks++;
        if ({busy, sampleValid, done} !== 3'b000 || accessIndex !== '0 || done_count != d0) begin
            errors++;
            $display("FAIL loop_stop got=%b idx=%h dones=%0d expected=000 idx=0 dones=0",
                     {busy, sampleValid, done}, accessIndex, done_count - d0);
        end
        loop_en = 1'b0;
    endtask

    task automatic test_underrun();
        int n;
        logic [DW-1:0] held;
        logic stable;
        sampleCount = 4;
        loop_en     = 1'b0;
        sampleReady = 1'b1;
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0101);
        pulse_start();
        wait_valid(n);
        @(negedge CLK_50Mhz);
        sampleReady = 1'b0;
        wait_valid(n);
        held   = sampleOut;
        stable = 1'b1;
        repeat (2 * CD) begin
            @(negedge CLK_50Mhz);
            if (!sampleValid || sampleOut !== held)
                stable = 1'b0;
        end
        checks++;
        if (!stable || underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_hold got=stable%b/underrun%b expected=1/1", stable, underrun);
        end
        sampleReady = 1'b1;
        @(negedge CLK_50Mhz);
        stop = 1'b1;
        @(negedge CLK_50Mhz);
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || underrun !== 1'b1 || sampleOut !== 16'h0101) begin
            errors++;
            $display("FAIL underrun_retained got=%b/%b/%h expected=0/1/0101", busy, underrun, sampleOut);
        end
        sampleCount = 1;
        exp_q.push_back(16'h0100);
        pulse_start();
        checks++;
        if (underrun !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL underrun_clear got=%b/%b expected=0/1", underrun, busy);
        end
        wait_valid(n);
        @(negedge CLK_50Mhz);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL single_sample_done got=%b expected=1", done);
        end
        @(negedge CLK_50Mhz);
    endtask

    task automatic test_stop();
        int d0;
        logic quiet;
        d0          = done_count;
        sampleCount = 4;
        loop_en     = 1'b0;
        sampleReady = 1'b1;
        pulse_start();
        stop = 1'b1;
        @(negedge CLK_50Mhz);
        stop = 1'b0;
        checks++;
        if ({busy, sampleValid, done} !== 3'b000 || accessIndex !== '0) begin
            errors++;
            $display("FAIL stop_in_fetch got=%b idx=%h expected=000 idx=0", {busy, sampleValid, done}, accessIndex);
        end
        quiet = 1'b1;
        repeat (FL + 2) begin
            @(negedge CLK_50Mhz);
            if (sampleValid || busy)
                quiet = 1'b0;
        end
        start = 1'b1;
        stop  = 1'b1;
        @(negedge CLK_50Mhz);
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (!quiet || busy !== 1'b0 || done_count != d0) begin
            errors++;
            $display("FAIL start_with_stop got=quiet%b/busy%b/dones%0d expected=1/0/0", quiet, busy, done_count - d0);
        end
    endtask

    task automatic test_zero_count();
        logic quiet;
        sampleCount = 0;
        pulse_start();
        quiet = 1'b1;
        repeat (FL + 2) begin
            if (busy || done || sampleValid)
                quiet = 1'b0;
            @(negedge CLK_50Mhz);
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL zero_count got=active expected=idle");
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        sampleCount = 3;
        loop_en     = 1'b0;
        sampleReady = 1'b1;
        for (int i = 0; i < 3; i++)
            exp_q.push_back(16'h0100 + 16'(i));
        pulse_start();
        start = 1'b1;
        @(negedge CLK_50Mhz);
        start = 1'b0;
        wait_valid(n);
        checks++;
        if (n + 1 != FL) begin
            errors++;
            $display("FAIL busy_start_fetch got=%0d expected=%0d", n + 1, FL);
        end
        @(negedge CLK_50Mhz);
        start = 1'b1;
        @(negedge CLK_50Mhz);
        start = 1'b0;
        wait_valid(n);
        checks++;
        if (n + 2 != CD) begin
            errors++;
            $display("FAIL busy_start_interval got=%0d expected=%0d", n + 2, CD);
        end
        @(negedge CLK_50Mhz);
        wait_valid(n);
        @(negedge CLK_50Mhz);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_done got=%b/%b expected=1/0", done, busy);
        end
        @(negedge CLK_50Mhz);
    endtask

    task automatic test_reset_mid();
        int n;
        sampleCount = 4;
        loop_en     = 1'b1;
        sampleReady = 1'b0;
        pulse_start();
        wait_valid(n);
        reset = 1'b1;
        @(negedge CLK_50Mhz);
        checks++;
        if ({busy, done, sampleValid, underrun} !== 4'b0000 || accessIndex !== '0 || sampleOut !== '0) begin
            errors++;
            $display("FAIL reset_mid got=%b idx=%h out=%h expected=0000 idx=0 out=0",
                     {busy, done, sampleValid, underrun}, accessIndex, sampleOut);
        end
        reset       = 1'b0;
        loop_en     = 1'b0;
        sampleReady = 1'b1;
        @(negedge CLK_50Mhz);
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        loop_en     = 1'b0;
        sampleCount = '0;
        sampleReady = 1'b1;
        test_reset();
        test_one_shot();
        test_loop();
        test_underrun();
        test_stop();
        test_zero_count();
        test_start_while_busy();
        test_reset_mid();
        test_one_shot();
        repeat (2) @(negedge CLK_50Mhz);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
